bin_to_bcd: RTL
===============

# bin_to_bcd

Sequential binary-to-BCD converter that sits directly downstream of the divider. It takes a 32-bit unsigned result (typically the divider's quotient or remainder) and produces packed decimal digits for the display path, using the shift-and-add-3 (double-dabble) algorithm. It converts one input bit per clock, using a start/busy/done handshake. Its outputs stay stable between conversions.

## Interface
- WIDTH, 32: binary input width. Must be at least 1.
- DIGITS, 10: number of BCD digits produced. Must satisfy DIGITS ≥ ceil(WIDTH·log10 2); the default of 10 covers 4 294 967 295.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of `value`. Sampled only when busy=0.
- value  input  WIDTH  unsigned binary operand. Captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd and digit_count are updated in the same cycle.
- bcd  output  4·DIGITS  packed BCD. Digit 0 (ones) is in bits [3:0].
- digit_count  output  4  number of significant decimal digits, 1..DIGITS.

## Operation
- Two states: IDLE and SHIFT.
- Internal registers:
  - working shift register: WIDTH binary bits plus 4·DIGITS BCD bits;
  - step counter, width clog2(WIDTH+1).
- IDLE, start=1 at an edge:
  - load the binary field with `value` and clear the BCD field;
  - clear the counter;
  - go to SHIFT; busy=1.
- SHIFT, each edge (one step):
  - for every BCD nibble ≥ 5, add 3 to that nibble, all nibbles in parallel;
  - shift the whole working register left by 1, so the binary MSB enters BCD bit 0;
  - increment the counter.
- On the step where the counter reaches WIDTH-1 (the WIDTH-th step):
  - write the resulting BCD field into `bcd`;
  - write digit_count: 1 + the index of the most significant nonzero nibble, or 1 if all nibbles are zero;
  - assert done for the following cycle;
  - return to IDLE; busy=0.
- start while busy=1 is ignored: not queued and not counted.
- Changes to `value` after the accepting edge have no effect.
- bcd and digit_count change only on completion. Intermediate working values are never visible.
- No nibble of bcd ever exceeds 9.
- reset=1 at any edge, including mid-conversion:
  - state goes to IDLE, and the working register and counter are cleared;
  - busy=0, done=0, bcd=0, digit_count=1;
  - the aborted conversion produces no done pulse.
- reset and start both high: reset wins and start is ignored.

## Timing
- Reset values: busy=0, done=0, bcd=0, digit_count=1.
- Start accepted at edge E0 → busy=1 from E0 until edge E_WIDTH.
- bcd, digit_count and done=1 are all valid after edge E_WIDTH. That is 32 cycles for the default parameters.
- done is high for exactly one cycle.
- busy is low during the done cycle, so a start in that cycle is accepted: back-to-back operation, one conversion per WIDTH+1 cycles.
- done and busy are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset behaviour: hold reset 3 cycles → busy=0, done=0, bcd=0, digit_count=1. start=1 together with reset → no busy.
- Basic conversions, each from a single start pulse:
  - value=0 → done exactly 32 cycles after the start edge, bcd=0x0000000000, digit_count=1;
  - value=9 → bcd=0x0000000009, digit_count=1;
  - value=30000 (the quotient of 60001/2) → bcd=0x0000030000, digit_count=5.
- Maximum value: value=0xFFFFFFFF → bcd=0x4294967295, digit_count=10. Every nibble ≤ 9 throughout.
- Start while busy: start with value=1600, then pulse start with value=7 at cycle 10 → a single done; bcd=0x0000001600, digit_count=4. Outputs hold the previous result until done.
- Reset mid-conversion: start with value=12345 and assert reset at cycle 15 → no done pulse, all outputs at reset values. A new start with value=42 → bcd=0x0000000042, digit_count=2.
- Back-to-back: start with value=100, then raise start with value=8 in the done cycle → second done exactly 33 cycles after the first; the results are 0x…0100 (digit_count=3) then 0x…0008 (digit_count=1).

Source files
------------

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble binary-to-BCD converter
// One binary bit per clock; result and digit count are registered on completion.
module bin_to_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            digit_count
);

  localparam int BW = 4 * DIGITS;
  localparam int TW = WIDTH + BW;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  work, work_nx, adj, shifted;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [BW-1:0]  bcd_nx;
  logic [3:0]     dc_nx;
  logic           done_nx;
  logic           last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      bcd         <= '0;
      digit_count <= 4'd1;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      work        <= work_nx;
      cnt         <= cnt_nx;
      bcd         <= bcd_nx;
      digit_count <= dc_nx;
      done        <= done_nx;
    end
  end

  assign busy = (state == SHIFT);

  // Add-3 correction on every BCD nibble in parallel, then shift the whole register.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[WIDTH+4*i +: 4] >= 4'd5)
        adj[WIDTH+4*i +: 4] = work[WIDTH+4*i +: 4] + 4'd3;
    end
    shifted = {adj[TW-2:0], 1'b0};
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    bcd_nx   = bcd;
    dc_nx    = digit_count;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_nx  = {{BW{1'b0}}, value};
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        work_nx = shifted;
        cnt_nx  = cnt + 1'b1;
        if (last) begin
          bcd_nx = shifted[WIDTH +: BW];
          dc_nx  = 4'd1;
          for (int i = 0; i < DIGITS; i++) begin
            if (shifted[WIDTH+4*i +: 4] != 4'd0)
              dc_nx = 4'(i + 1);
          end
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
